// File: rtl/wdg_multi.sv
// wdg_multi: multi-channel two-stage watchdog behind a pipelined Wishbone slave
module wdg_multi #(
    parameter int          NUM_CH            = 4,
    parameter int          CNT_WIDTH         = 10,
    parameter int          REG_ADDRESS_WIDTH = 6,
    parameter int          WB_DATA_WIDTH     = 32,
    parameter logic [31:0] KICK_KEY          = 32'h0000_005A
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         wdg_tick,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    input  logic                         i_wb_we,
    input  logic [REG_ADDRESS_WIDTH-1:0] i_wb_adr,
    input  logic [WB_DATA_WIDTH-1:0]     i_wb_dat,
    input  logic [3:0]                   i_wb_sel,
    output logic                         o_wb_stall,
    output logic                         o_wb_ack,
    output logic [WB_DATA_WIDTH-1:0]     o_wb_dat,
    output logic [NUM_CH-1:0]            o_wdg_irq,
    output logic [NUM_CH-1:0]            o_wdg_rst
);
    localparam int CHW = REG_ADDRESS_WIDTH - 3;

    logic                     accept;
    logic [CHW-1:0]           ch_idx;
    logic [WB_DATA_WIDTH-1:0] wmask;
    logic [WB_DATA_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] csr_w [NUM_CH];
    logic [WB_DATA_WIDTH-1:0] cnt_w [NUM_CH];
    logic                     unused_ok;

    // The ack cycle doubles as the stall cycle, so only one request is ever in flight.
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign o_wb_stall = o_wb_ack;
    assign ch_idx     = i_wb_adr[REG_ADDRESS_WIDTH-1:3];
    assign wmask      = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign unused_ok  = ^{i_wb_adr[1:0], wmask[3:1], wmask[WB_DATA_WIDTH-1:4+CNT_WIDTH]};

    // Read mux: addresses past the last channel fall through to zero.
    always_comb begin
        rd = '0;
        for (int c = 0; c < NUM_CH; c++)
            rd = (ch_idx == CHW'(c)) ? (i_wb_adr[2] ? cnt_w[c] : csr_w[c]) : rd;
    end

    // Bus response: ack and data one cycle after acceptance, data zero otherwise.
    always_ff @(posedge clk) begin
        if (res) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            o_wb_ack <= accept;
            o_wb_dat <= (accept & ~i_wb_we) ? rd : '0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                 en_q, stage_q, rst_q;
        logic [CNT_WIDTH-1:0] wto_q, cnt_q, new_wto;
        logic                 hit, wr_csr, kick;

        assign hit     = accept & i_wb_we & (ch_idx == CHW'(c));
        assign wr_csr  = hit & ~i_wb_adr[2];
        assign kick    = hit & i_wb_adr[2] & en_q & (i_wb_sel == 4'hF) & (i_wb_dat == KICK_KEY);
        assign new_wto = (i_wb_dat[4+:CNT_WIDTH] & wmask[4+:CNT_WIDTH]) | (wto_q & ~wmask[4+:CNT_WIDTH]);
        assign csr_w[c] = {{(WB_DATA_WIDTH-4-CNT_WIDTH){1'b0}}, wto_q, 2'b00, stage_q, en_q};
        assign cnt_w[c] = {stage_q, {(WB_DATA_WIDTH-1-CNT_WIDTH){1'b0}}, cnt_q};
        assign o_wdg_irq[c] = stage_q;
        assign o_wdg_rst[c] = rst_q;

        // Channel state: bus write or kick reloads and wins over a tick in the same cycle.
        always_ff @(posedge clk) begin
            if (res) begin
                en_q    <= 1'b0;
                stage_q <= 1'b0;
                rst_q   <= 1'b0;
                wto_q   <= '0;
                cnt_q   <= '0;
            end else if (wr_csr) begin
                en_q    <= wmask[0] ? i_wb_dat[0] : en_q;
                wto_q   <= new_wto;
                cnt_q   <= new_wto;
                stage_q <= 1'b0;
            end else if (kick) begin
                cnt_q   <= wto_q;
                stage_q <= 1'b0;
            end else if (en_q & wdg_tick) begin
                if (cnt_q != '0)
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                else if (!stage_q) begin
                    stage_q <= 1'b1;
                    cnt_q   <= wto_q;
                end else
                    rst_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wdg_multi.sv
// tb_wdg_multi: scoreboard bench for wdg_multi against a behavioural channel model
module tb_wdg_multi;
    localparam int          NCH = 4;
    localparam int          CW  = 10;
    localparam logic [31:0] KEY = 32'h0000_005A;

    logic            clk_tb = 1'b0;
    logic            res = 1'b1, wdg_tick = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [5:0]      adr = '0;
    logic [31:0]     dat = '0;
    logic [3:0]      sel = '0;
    logic            stall, ack;
    logic [31:0]     rdat;
    logic [NCH-1:0]  irq, wrst;

    wdg_multi #(.NUM_CH(NCH), .CNT_WIDTH(CW), .REG_ADDRESS_WIDTH(6), .WB_DATA_WIDTH(32), .KICK_KEY(KEY)) dut (
        .clk(clk_tb), .res(res), .wdg_tick(wdg_tick),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_dat(rdat),
        .o_wdg_irq(irq), .o_wdg_rst(wrst)
    );

    always #5 clk_tb = ~clk_tb;

    typedef struct {logic [31:0] d; int cy;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cyc_n = 0;
    int m_en[NCH], m_wto[NCH], m_cnt[NCH], m_stage[NCH], m_rst[NCH];
    bit m_ack = 1'b0;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc_n);
        end
    endfunction

    // Reference model: applies the register/tick rules for the edge just taken.
    function automatic void model_edge();
        bit          wrote[NCH];
        bit          acc;
        int          ch;
        logic [31:0] rv, nw;
        exp_t        e;
        cyc_n++;
        foreach (wrote[c]) wrote[c] = 1'b0;
        if (res) begin
            foreach (m_en[c]) begin
                m_en[c] = 0; m_wto[c] = 0; m_cnt[c] = 0; m_stage[c] = 0; m_rst[c] = 0;
            end
            m_ack = 1'b0;
            return;
        end
        acc = cyc && stb && !m_ack;
        if (acc) begin
            ch = int'(adr) / 8;
            rv = '0;
            if (ch < NCH)
                rv = adr[2] ? ((32'(m_stage[ch]) << 31) | 32'(m_cnt[ch]))
                            : ((32'(m_wto[ch]) << 4) | (32'(m_stage[ch]) << 1) | 32'(m_en[ch]));
            e.d = we ? 32'd0 : rv;
            e.cy = cyc_n;
            q.push_back(e);
            if (we && ch < NCH) begin
                if (!adr[2]) begin
                    nw = rv;
                    for (int b = 0; b < 4; b++) if (sel[b]) nw[8*b+:8] = dat[8*b+:8];
                    m_en[ch] = int'(nw[0]);
                    m_wto[ch] = int'(nw >> 4) % (1 << CW);
                    m_cnt[ch] = m_wto[ch];
                    m_stage[ch] = 0;
                    wrote[ch] = 1'b1;
                end else if (dat == KEY && sel == 4'hF && m_en[ch] != 0) begin
                    m_cnt[ch] = m_wto[ch];
                    m_stage[ch] = 0;
                    wrote[ch] = 1'b1;
                end
            end
        end
        if (wdg_tick)
            for (int c = 0; c < NCH; c++)
                if (!wrote[c] && m_en[c] != 0) begin
                    if (m_cnt[c] > 0) m_cnt[c]--;
                    else if (m_stage[c] == 0) begin m_stage[c] = 1; m_cnt[c] = m_wto[c]; end
                    else m_rst[c] = 1;
                end
        m_ack = acc;
    endfunction

    function automatic logic [31:0] vec(input int k);
        logic [31:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c] = (k != 0) ? (m_rst[c] != 0) : (m_stage[c] != 0);
        return v;
    endfunction

    // Monitor: pops the scoreboard on every ack and tracks the watchdog outputs each cycle.
    always @(negedge clk_tb) begin : mon
        exp_t e;
        if (ack) begin
            if (q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
            else begin
                e = q.pop_front();
                chk("ack_latency", 32'(cyc_n), 32'(e.cy));
                chk("rd_data", rdat, e.d);
                chk("stall_in_ack", 32'(stall), 32'd1);
            end
        end else begin
            if (q.size() != 0 && q[0].cy <= cyc_n) begin
                chk("missing_ack", 32'(ack), 32'd1);
                void'(q.pop_front());
            end
            chk("idle_dat", rdat, 32'd0);
        end
        chk("irq", 32'(irq), vec(0));
        chk("rst", 32'(wrst), vec(1));
    end

    task automatic cycle();
        @(posedge clk_tb);
        model_edge();
        #1;
        wdg_tick = 1'b0;
        res = 1'b0;
    endtask

    task automatic wb(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic t1, input logic t2);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; wdg_tick = t1;
        cycle();
        wdg_tick = t2;
        cycle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        wb(1'b0, a, 32'd0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wb(1'b1, a, d, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic tick4(input int n);
        repeat (n) begin
            wdg_tick = 1'b1;
            cycle();
            repeat (3) cycle();
        end
    endtask

    task automatic do_reset();
        res = 1'b1;
        cycle();
        res = 1'b1;
        cycle();
    endtask

    initial begin
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            rd(6'(8 * c));
            rd(6'(8 * c + 4));
        end
        wr(6'h00, 32'h0000_0101);
        tick4(5);
        rd(6'h04);
        tick4(11);
        chk("irq_before_17", 32'(irq[0]), 32'd0);
        tick4(1);
        chk("irq_at_17", 32'(irq[0]), 32'd1);
        rd(6'h04);
        tick4(16);
        chk("rst_before_34", 32'(wrst[0]), 32'd0);
        tick4(1);
        chk("rst_at_34", 32'(wrst[0]), 32'd1);

        do_reset();
        wr(6'h00, 32'h0000_0101);
        tick4(10);
        wr(6'h04, KEY);
        rd(6'h04);
        chk("kick_no_irq", 32'(irq[0]), 32'd0);
        tick4(3);
        wr(6'h04, 32'h0000_005B);
        wb(1'b1, 6'h04, KEY, 4'b0011, 1'b0, 1'b0);
        rd(6'h04);

        do_reset();
        wr(6'h00, 32'h0000_0021);
        tick4(5);
        wb(1'b1, 6'h04, KEY, 4'hF, 1'b1, 1'b0);
        chk("collision_rst", 32'(wrst[0]), 32'd0);
        chk("collision_irq", 32'(irq[0]), 32'd0);
        rd(6'h04);

        do_reset();
        wr(6'h08, 32'h0000_0021);
        wr(6'h10, 32'h0000_0051);
        tick4(3);
        chk("indep_irq", 32'(irq), 32'h2);
        wr(6'h08, 32'h0000_0020);
        chk("disable_irq", 32'(irq), 32'h0);
        rd(6'h14);

        wr(6'h00, 32'h0000_0001);
        wdg_tick = 1'b1; cycle();
        wdg_tick = 1'b1; cycle();
        chk("rst_set", 32'(wrst[0]), 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h04; res = 1'b1;
        cycle();
        cyc = 1'b0; stb = 1'b0;
        chk("res_ack", 32'(ack), 32'd0);
        chk("res_outputs", 32'({irq, wrst}), 32'd0);
        cycle();
        chk("res_no_late_ack", 32'(ack), 32'd0);
        rd(6'h3C);

        repeat (300) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else if ($urandom_range(0, 2) == 0) begin
                wdg_tick = 1'($urandom_range(0, 2) == 0);
                cycle();
            end else
                wb(1'($urandom_range(0, 1)), 6'($urandom_range(0, 39)),
                   ($urandom_range(0, 3) == 0) ? KEY : (($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 6)) << 4)),
                   ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end
        repeat (3) cycle();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wdg_multi.md
Name: wdg_multi

Overview:
- Multi-channel, two-stage watchdog with a Wishbone pipelined slave interface. Generalises the single-channel watchdog.
- Adds the following:
  - NUM_CH independent channels, each with a configurable counter width.
  - A key-protected kick register.
  - A first-timeout interrupt stage and a second-timeout reset-request stage.
- Channels count down on a shared external tick pulse supplied by the mtime block. Outputs feed the interrupt controller and the system reset generator.

Parameters:
- NUM_CH, 4, number of watchdog channels (1..8).
- CNT_WIDTH, 10, width of the WTOCNT field and of each down-counter (1..27).
- REG_ADDRESS_WIDTH, 6, Wishbone byte-address width. Must satisfy 2^REG_ADDRESS_WIDTH >= 8*NUM_CH.
- WB_DATA_WIDTH, 32, Wishbone data width (fixed 32).
- KICK_KEY, 32'h0000_005A, value whose write to a KICK register reloads the channel.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- res  in  1  synchronous, active-high reset.
- wdg_tick  in  1  single-cycle tick pulse from mtime; one decrement per high cycle.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  write enable.
- i_wb_adr  in  REG_ADDRESS_WIDTH  byte address.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte selects.
- o_wb_stall  out  1  stall.
- o_wb_ack  out  1  acknowledge.
- o_wb_dat  out  32  read data.
- o_wdg_irq  out  NUM_CH  per-channel stage-1 timeout interrupt (level).
- o_wdg_rst  out  NUM_CH  per-channel stage-2 reset request (sticky).

Behaviour:
- Reset values (res=1 at a clk edge): o_wb_ack=0, o_wb_stall=0, o_wb_dat=0, o_wdg_irq=0, o_wdg_rst=0. All EN=0, WTOCNT=0, counters=0, stage=0. Reset mid-transaction drops the pending ack.
- Register map: channel c occupies base 8*c.
  - Offset 0, WDCSR (RW):
    - bit0 EN.
    - bit1 STAGE (RO, current stage).
    - bits3:2 reserved (read 0).
    - bits[4+CNT_WIDTH-1:4] WTOCNT.
    - Upper bits read 0.
  - Offset 4, KICK/CNT:
    - Read returns {STAGE, zeros, counter}, with counter in the low CNT_WIDTH bits and STAGE in bit31.
    - Write with full data == KICK_KEY kicks the channel. Any other write is ignored.
  - Addresses beyond channel NUM_CH-1 read 0, ignore writes, and are still acked.
- Handshake:
  - A request is accepted when i_wb_cyc & i_wb_stb & !o_wb_stall.
  - o_wb_ack is high exactly one cycle later. o_wb_dat is valid in that same ack cycle and 0 otherwise.
  - o_wb_stall=1 during the ack cycle, so at most one transaction is outstanding and throughput is 1 per 2 cycles.
  - If i_wb_cyc drops before ack, ack still fires.
- Byte selects:
  - WDCSR writes update only selected bytes.
  - A KICK write requires i_wb_sel=4'b1111; otherwise it is ignored.
- WDCSR write effect, applied in the cycle after acceptance (ack cycle):
  - counter <= new WTOCNT, stage <= 0, irq <= 0.
  - If new EN=0, the counter is instead held at the new WTOCNT and no decrement occurs.
- Kick: same reload as a WDCSR write (counter <= WTOCNT, stage <= 0, irq <= 0), only when EN=1.
- Counting, per channel with EN=1, on a cycle with wdg_tick=1:
  - If counter != 0: counter <= counter-1.
  - If counter == 0 and stage=0: stage <= 1, o_wdg_irq[c] <= 1, counter <= WTOCNT.
  - If counter == 0 and stage=1: o_wdg_rst[c] <= 1 (sticky until res), counter holds at 0, irq stays 1.
- WTOCNT=0: a stage escalation occurs on every tick.
- Priority in the same cycle: register write/kick beats tick. A kick arriving in the cycle the counter hits 0 prevents escalation.
- Disabling (EN=0): irq and stage clear, counter freezes, o_wdg_rst is unaffected.
- Channels are fully independent. A tick affects all enabled channels simultaneously.
- Arithmetic is unsigned. There is no wrap below 0.

Test Plan:
- Reset then read all registers:
  - After res high 2 cycles then low, read 0x00 and 0x04 of ch0..3 -> all return 0.
  - Each ack arrives exactly 1 cycle after acceptance, with stall high during the ack cycle.
- Basic timeout, ch0:
  - Write WDCSR=0x0000_0101 (EN=1, WTOCNT=0x10), then pulse wdg_tick every 4 cycles.
  - Expect: CNT read after 5 ticks = 0x0B.
  - Expect: o_wdg_irq[0] rises on the 17th tick with counter reloaded to 0x10.
  - Expect: o_wdg_rst[0] rises on the 34th tick.
- Kick:
  - Repeat the basic-timeout setup, then write 0x5A to 0x04 after 10 ticks -> counter=0x10, no irq.
  - Write 0x5B or sel=4'b0011 instead -> ignored, counter keeps counting down.
- Kick collision: a kick lands in the same cycle as the tick that would take the counter to 0 from stage 1 -> no o_wdg_rst, counter=WTOCNT, irq=0.
- Independence and disable:
  - Setup: ch1 WTOCNT=2, ch2 WTOCNT=5, both enabled.
  - Expect: after 3 ticks only irq[1]=1.
  - Then write ch1 EN=0 -> irq[1] clears next cycle and ch2 is unaffected.
- Reset mid-operation and out-of-range:
  - Assert res while o_wdg_rst[0]=1 and an ack is pending -> all outputs 0 next cycle and no ack emitted.
  - Read 0x3C with NUM_CH=4 -> ack with data 0.
